// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter with a byte FIFO, 8N1 framing by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_RESET = 2604
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  localparam int unsigned PtrW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;

  // Control registers
  logic            tx_en_q, irq_en_q;
  logic [15:0]     div_q;

  // Transmit FSM state
  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     period_q, period_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic            empty, full, busy;
  logic            wr_data, wr_status, wr_ctrl, wr_div;
  logic            push, pop, load;
  logic            bit_end, start_ok;
  logic [7:0]      head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthCnt);
  assign busy      = (state_q != StIdle);
  assign head      = mem_q[rptr_q];

  assign wr_data   = WE && (Addr == 2'd0);
  assign wr_status = WE && (Addr == 2'd1);
  assign wr_ctrl   = WE && (Addr == 2'd2);
  assign wr_div    = WE && (Addr == 2'd3);

  // Fullness is judged before any same-edge pop, so a push into a full FIFO is always lost.
  assign push      = wr_data && !full;
  assign start_ok  = tx_en_q && !empty;
  assign bit_end   = (cnt_q == period_q - 16'd1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= Din[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= 16'(DIV_RESET);
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (wr_data && full) begin
        ovf_q <= 1'b1;
      end else if (wr_status) begin
        ovf_q <= 1'b0;
      end
      if (wr_ctrl) begin
        tx_en_q  <= Din[0];
        irq_en_q <= Din[1];
      end
      if (wr_div) begin
        div_q <= (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= 16'd1;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? 16'd0 : cnt_q + 16'd1;
    period_d = period_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    load     = 1'b0;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        txd_d = 1'b1;
        load  = start_ok;
      end
      StStart: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = StParity;
`else
            txd_d   = 1'b1;
            state_d = StStop;
`endif
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = StIdle;
          load    = start_ok;
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase

    // Shared frame launch from IDLE or straight out of STOP (back-to-back frames).
    if (load) begin
      pop      = 1'b1;
      shift_d  = head;
      period_d = div_q;
      cnt_d    = '0;
      txd_d    = 1'b0;
      state_d  = StStart;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      2'd1: begin
        Dout[0]    = empty;
        Dout[1]    = full;
        Dout[2]    = busy;
        Dout[3]    = ovf_q;
        Dout[15:8] = 8'(count_q);
      end
      2'd2: begin
        Dout[0] = tx_en_q;
        Dout[1] = irq_en_q;
      end
      2'd3: begin
        Dout[15:0] = div_q;
      end
      default: Dout = '0;
    endcase
  end

  assign IRQ = irq_en_q && empty && !busy;
  assign txd = txd_q;

  logic unused_din;
  assign unused_din = ^Din[31:16];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed/randomised bench for uart_tx_fifo against a queue-based behavioural model.
module tb_uart_tx_fifo;

  localparam int unsigned Depth    = 16;
  localparam int unsigned DivReset = 2604;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [7:0]  q_model[$];
  bit          ovf_m;
  int unsigned div_m;

  uart_tx_fifo #(
    .DEPTH     (Depth),
    .DIV_RESET (DivReset)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit i of a frame carrying byte b: start, 8 data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status(input bit busy);
    logic [31:0] s;
    s        = '0;
    s[0]     = (q_model.size() == 0);
    s[1]     = (q_model.size() == Depth);
    s[2]     = busy;
    s[3]     = ovf_m;
    s[15:8]  = 8'(q_model.size());
    return s;
  endfunction

  task automatic model_reset();
    q_model.delete();
    ovf_m = 1'b0;
    div_m = DivReset;
  endtask

  // Called at a negedge; the write is sampled by the next posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    case (a)
      2'd0: if (q_model.size() < Depth) q_model.push_back(d[7:0]); else ovf_m = 1'b1;
      2'd1: ovf_m = 1'b0;
      2'd3: div_m = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
      default: ;
    endcase
    @(negedge clk);
    WE   = 1'b0;
    Din  = '0;
    Addr = 2'd1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v    = Dout;
    Addr = 2'd1;
  endtask

  // Checks nf consecutive frames cycle by cycle, starting the negedge after launch.
  task automatic check_frames(input int nf);
    logic [7:0]  b;
    logic [31:0] v;
    for (int f = 0; f < nf; f++) begin
      b = q_model.pop_front();
      for (int i = 0; i < NBits; i++) begin
        for (int c = 0; c < int'(div_m); c++) begin
          @(negedge clk);
          chk("frame_txd", {31'b0, txd}, {31'b0, frame_bit(b, i)});
          rd(2'd1, v);
          chk("frame_status", v, exp_status(1'b1));
          chk("frame_irq", {31'b0, IRQ}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  cur;
    int unsigned d;
    int          j;

    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 2'd1;
    Din   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    rd(2'd1, v); chk("reset_status", v, 32'h0000_0001);
    rd(2'd2, v); chk("reset_ctrl", v, 32'd0);
    rd(2'd3, v); chk("reset_div", v, 32'd2604);
    rd(2'd0, v); chk("reset_data", v, 32'd0);
    chk("reset_txd", {31'b0, txd}, 32'd1);
    chk("reset_irq", {31'b0, IRQ}, 32'd0);

    wr(2'd3, 32'd0);
    rd(2'd3, v); chk("div_zero", v, 32'd1);

    // Single frames: the first is the 0xA5 / divisor-4 case, then random ones.
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 4 : $urandom_range(1, 6);
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      wr(2'd3, d);
      if (k == 0) wr(2'd2, 32'd1);
      rd(2'd3, v); chk("div_rb", v, d);
      wr(2'd0, {24'b0, b});
      rd(2'd1, v); chk("queued_status", v, exp_status(1'b0));
      chk("queued_txd", {31'b0, txd}, 32'd1);
      check_frames(1);
      @(negedge clk);
      rd(2'd1, v); chk("after_status", v, exp_status(1'b0));
      chk("after_txd", {31'b0, txd}, 32'd1);
      chk("after_irq", {31'b0, IRQ}, 32'd0);
    end

    // Overflow with transmitter disabled.
    wr(2'd2, 32'd0);
    for (int i = 0; i <= int'(Depth); i++) wr(2'd0, $urandom);
    rd(2'd1, v); chk("full_status", v, exp_status(1'b0));
    chk("full_flags", v & 32'h0000_FF0A, {16'b0, 8'(Depth), 8'h0A});
    wr(2'd1, $urandom);
    rd(2'd1, v); chk("ovf_clear", v, exp_status(1'b0));

    // Enable with a full FIFO; push lands on the same edge as the first pop.
    wr(2'd2, 32'd1);
    wr(2'd0, $urandom);
    cur = q_model.pop_front();
    rd(2'd1, v); chk("pushpop_status", v, exp_status(1'b1));
    chk("pushpop_count", {24'b0, v[15:8]}, Depth - 1);
    chk("pushpop_ovf", {31'b0, v[3]}, 32'd1);
    chk("pushpop_txd", {31'b0, txd}, 32'd0);
    j = int'(div_m) + int'(div_m) / 2 + 1;
    repeat (j) @(negedge clk);
    chk("mid_data_txd", {31'b0, txd}, {31'b0, frame_bit(cur, j / int'(div_m))});

    // Reset in the middle of the data bits.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_txd", {31'b0, txd}, 32'd1);
    rd(2'd1, v); chk("rst_status", v, 32'h0000_0001);
    rd(2'd2, v); chk("rst_ctrl", v, 32'd0);
    rd(2'd3, v); chk("rst_div", v, 32'd2604);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("rst_quiet_txd", {31'b0, txd}, 32'd1);
    end

    // Back-to-back frames with interrupt enabled.
    d = $urandom_range(2, 5);
    wr(2'd3, d);
    wr(2'd0, $urandom);
    wr(2'd0, $urandom);
    wr(2'd2, 32'd3);
    chk("b2b_pre_irq", {31'b0, IRQ}, 32'd0);
    chk("b2b_pre_txd", {31'b0, txd}, 32'd1);
    check_frames(2);
    @(negedge clk);
    chk("b2b_irq_rise", {31'b0, IRQ}, 32'd1);
    rd(2'd1, v); chk("b2b_status", v, 32'h0000_0001);
    chk("b2b_txd", {31'b0, txd}, 32'd1);
    wr(2'd0, $urandom);
    chk("irq_drop", {31'b0, IRQ}, 32'd0);
    check_frames(1);
    @(negedge clk);
    chk("irq_again", {31'b0, IRQ}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
